// File: rtl/multadd_seq_ctrl.sv
// Multiply-add sequencer driving one shared external pipelined 16x16 multiplier.
// Optional macro MULTADD_SAT_EN: saturate oR on overflow and add the oSAT output.
module multadd_seq_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int OUT_W   = 17
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iSEL,
  input  logic [7:0]       iA0,
  input  logic [7:0]       iA1,
  input  logic [7:0]       iB0,
  input  logic [7:0]       iB1,
  output logic [15:0]      oM_A,
  output logic [15:0]      oM_B,
  output logic             oM_VLD,
  input  logic [31:0]      iM_P,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [OUT_W-1:0] oR,
  output logic             oBUSY,
`ifdef MULTADD_SAT_EN
  output logic             oSAT,
`endif
  output logic [1:0]       oDBG_STATE
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // the source holds valid and data stable until then, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  state_t            state_q, state_d;
  logic              sel_q;
  logic [7:0]        a0_q, a1_q, b0_q, b1_q;
  logic [15:0]       p0_q, p1_q;
  logic [32:0]       acc_q;
  logic [32:0]       acc_sum;
  logic [1:0]        k_q;
  logic [3:0]        cnt_q;
  logic              last_wait;
  logic [OUT_W-1:0]  r_q;
  logic [OUT_W-1:0]  r_next;
`ifdef MULTADD_SAT_EN
  logic              sat_q;
  logic              sat_next;
`endif

  assign acc_sum    = acc_q + 33'(iM_P);
  assign last_wait  = (cnt_q == CNT_LAST);
  assign oR         = r_q;
  assign oDBG_STATE = state_q;

`ifdef MULTADD_SAT_EN
  assign sat_next = ((34'(acc_sum) >> OUT_W) != 34'd0);
  assign r_next   = sat_next ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
  assign oSAT     = sat_q && (state_q == DONE);
`else
  assign r_next   = acc_sum[OUT_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    oREADY  = 1'b0;
    oM_VLD  = 1'b0;
    oM_A    = 16'd0;
    oM_B    = 16'd0;
    oVALID  = 1'b0;
    oBUSY   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        oREADY = 1'b1;
        if (iVALID) state_d = ISSUE;
      end
      ISSUE: begin
        oM_VLD = 1'b1;
        case (k_q)
          2'd0:    begin oM_A = {8'd0, a0_q}; oM_B = {8'd0, b0_q}; end
          2'd1:    begin oM_A = {8'd0, a1_q}; oM_B = {8'd0, b1_q}; end
          default: begin oM_A = p0_q;         oM_B = p1_q;         end
        endcase
        state_d = WAIT;
      end
      WAIT: begin
        if (last_wait) begin
          if (k_q == 2'd0)      state_d = ISSUE;
          else if (k_q == 2'd1) state_d = sel_q ? DONE : ISSUE;
          else                  state_d = DONE;
        end
      end
      DONE: begin
        oVALID = 1'b1;
        if (iREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      a0_q    <= 8'd0;
      a1_q    <= 8'd0;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      p0_q    <= 16'd0;
      p1_q    <= 16'd0;
      acc_q   <= 33'd0;
      k_q     <= 2'd0;
      cnt_q   <= 4'd0;
      r_q     <= '0;
`ifdef MULTADD_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (iVALID) begin
            sel_q <= iSEL;
            a0_q  <= iA0;
            a1_q  <= iA1;
            b0_q  <= iB0;
            b1_q  <= iB1;
            acc_q <= 33'd0;
            k_q   <= 2'd0;
          end
        end
        ISSUE: cnt_q <= 4'd0;
        WAIT: begin
          if (last_wait) begin
            // Only this cycle carries our product; iM_P is don't-care elsewhere.
            acc_q <= acc_sum;
            if (k_q == 2'd0) p0_q <= iM_P[15:0];
            if (k_q == 2'd1) p1_q <= iM_P[15:0];
            k_q <= k_q + 2'd1;
            if (state_d == DONE) begin
              r_q   <= r_next;
`ifdef MULTADD_SAT_EN
              sat_q <= sat_next;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multadd_seq_ctrl.sv
// Bench for multadd_seq_ctrl: timeline reference model, pipelined multiplier model, directed + random ops.
// Honours MULTADD_SAT_EN the same way the design does.
module tb_multadd_seq_ctrl;

  localparam int L     = 2;
  localparam int OUT_W = 17;

  logic             iCLK, iRST, iVALID, oREADY, iSEL;
  logic [7:0]       iA0, iA1, iB0, iB1;
  logic [15:0]      oM_A, oM_B;
  logic             oM_VLD;
  logic [31:0]      iM_P;
  logic             oVALID, iREADY, oBUSY;
  logic [OUT_W-1:0] oR;
  logic [1:0]       oDBG_STATE;
`ifdef MULTADD_SAT_EN
  logic             oSAT;
`endif

  multadd_seq_ctrl #(.MUL_LAT(L), .OUT_W(OUT_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY), .iSEL(iSEL),
    .iA0(iA0), .iA1(iA1), .iB0(iB0), .iB1(iB1),
    .oM_A(oM_A), .oM_B(oM_B), .oM_VLD(oM_VLD), .iM_P(iM_P),
    .oVALID(oVALID), .iREADY(iREADY), .oR(oR), .oBUSY(oBUSY),
`ifdef MULTADD_SAT_EN
    .oSAT(oSAT),
`endif
    .oDBG_STATE(oDBG_STATE)
  );

  // ---------------- clock / reset / counters ----------------
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- external multiplier model ----------------
  typedef struct {int c; logic [31:0] p;} mq_t;
  mq_t mq[$];
  mq_t mq_tmp;

  always @(posedge iCLK) begin
    #1;
    cyc++;
    while (mq.size() > 0 && mq[0].c + L < cyc) void'(mq.pop_front());
    if (mq.size() > 0 && mq[0].c + L == cyc) begin
      iM_P = mq[0].p;
      void'(mq.pop_front());
    end else begin
      iM_P = $urandom;
    end
  end

  // ---------------- reference model ----------------
  function automatic longint f_res(input longint v);
`ifdef MULTADD_SAT_EN
    if (v >= (longint'(1) << OUT_W)) return (longint'(1) << OUT_W) - 1;
    return v;
`else
    return v % (longint'(1) << OUT_W);
`endif
  endfunction

  logic [OUT_W-1:0] exp_q[$];
  logic             sat_q_m[$];
  bit               armed = 0;
  bit               m_idle = 1;
  int               m_done;
  int               m_ic[3];
  longint           m_ia[3], m_ib[3];
  int               m_n;
  longint           m_r = 0;
  bit               m_sat = 0;

  always @(negedge iCLK) begin
    bit     e_valid, e_mvld;
    longint e_ma, e_mb, p0, p1, res;
    if (armed) begin
      if (!m_idle && cyc == m_done && exp_q.size() > 0) begin
        m_r   = exp_q.pop_front();
        m_sat = sat_q_m.pop_front();
      end
      e_valid = !m_idle && (cyc >= m_done);
      e_mvld = 0; e_ma = 0; e_mb = 0;
      if (!m_idle)
        for (int i = 0; i < m_n; i++)
          if (cyc == m_ic[i]) begin e_mvld = 1; e_ma = m_ia[i]; e_mb = m_ib[i]; end
      check("ready",  oREADY, m_idle);
      check("busy",   oBUSY,  !m_idle);
      check("valid",  oVALID, e_valid);
      check("m_vld",  oM_VLD, e_mvld);
      check("m_a",    oM_A,   e_ma);
      check("m_b",    oM_B,   e_mb);
      check("r",      oR,     m_r);
`ifdef MULTADD_SAT_EN
      check("sat",    oSAT,   e_valid && m_sat);
`endif
    end
    if (oM_VLD === 1'b1) begin
      mq_tmp.c = cyc;
      mq_tmp.p = 32'(oM_A) * 32'(oM_B);
      mq.push_back(mq_tmp);
    end
    if (iRST) begin
      armed  = 1;
      m_idle = 1;
      m_r    = 0;
      m_sat  = 0;
      exp_q.delete();
      sat_q_m.delete();
    end else if (armed) begin
      if (m_idle) begin
        if (iVALID) begin
          p0 = longint'(iA0) * longint'(iB0);
          p1 = longint'(iA1) * longint'(iB1);
          res = iSEL ? p0 + p1 : p0 + p1 + p0 * p1;
          exp_q.push_back(OUT_W'(f_res(res)));
          sat_q_m.push_back(res >= (longint'(1) << OUT_W));
          m_ic[0] = cyc + 1;             m_ia[0] = iA0; m_ib[0] = iB0;
          m_ic[1] = cyc + 1 + (L + 1);   m_ia[1] = iA1; m_ib[1] = iB1;
          m_ic[2] = cyc + 1 + 2*(L + 1); m_ia[2] = p0;  m_ib[2] = p1;
          m_n    = iSEL ? 2 : 3;
          m_done = iSEL ? cyc + 3 + 2*L : cyc + 4 + 3*L;
          m_idle = 0;
        end
      end else if (cyc >= m_done && iREADY) begin
        m_idle = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_ops(input logic sel, input logic [7:0] a0, b0, a1, b1);
    iSEL = sel; iA0 = a0; iB0 = b0; iA1 = a1; iB1 = b1;
  endtask

  task automatic wait_valid(output int c);
    int n;
    n = 0;
    @(negedge iCLK);
    while (oVALID !== 1'b1 && n < 80) begin
      @(negedge iCLK);
      n++;
    end
    if (oVALID !== 1'b1) check("wait_valid_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic run_op(input logic sel, input logic [7:0] a0, b0, a1, b1,
                        input int exp_lat, input longint exp_r, input string name);
    int c0, c1;
    tick();
    drive_ops(sel, a0, b0, a1, b1);
    iVALID = 1'b1;
    @(negedge iCLK);
    c0 = cyc;
    tick();
    iVALID = 1'b0;
    drive_ops($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
    wait_valid(c1);
    check({name, "_lat"}, c1 - c0, exp_lat);
    check({name, "_r"}, oR, exp_r);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1;
    iRST = 1'b1; iVALID = 1'b0; iREADY = 1'b1;
    drive_ops(0, 0, 0, 0, 0);
    iM_P = 32'd0;
    repeat (3) tick();
    iRST = 1'b0;
    tick();

    run_op(1, 3, 4, 5, 6, 7, 42, "t1");
    run_op(0, 3, 4, 5, 6, 10, 402, "t2");
    run_op(1, 255, 255, 255, 255, 7, 130050, "t3_sel1");
`ifdef MULTADD_SAT_EN
    run_op(0, 255, 255, 255, 255, 10, 131071, "t3_sel0");
`else
    run_op(0, 255, 255, 255, 255, 10, 129027, "t3_sel0");
`endif

    // consumer stall: result must hold, new requests ignored
    iREADY = 1'b0;
    tick();
    drive_ops(1, 3, 4, 5, 6);
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    wait_valid(c1);
    for (int i = 0; i < 5; i++) begin
      tick();
      iVALID = $urandom_range(0, 1);
      drive_ops($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
      @(negedge iCLK);
      check("t4_hold_r", oR, 42);
      check("t4_hold_valid", oVALID, 1);
      check("t4_ready_low", oREADY, 0);
    end
    tick();
    iVALID = 1'b0;
    iREADY = 1'b1;
    repeat (2) tick();

    // reset during the second multiply's wait
    drive_ops(0, 7, 9, 11, 13);
    iVALID = 1'b1;
    @(negedge iCLK);
    c0 = cyc;
    tick();
    iVALID = 1'b0;
    repeat (4) tick();
    check("t5_reset_cycle", cyc - c0, 5);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    @(negedge iCLK);
    check("t5_ready", oREADY, 1);
    check("t5_busy", oBUSY, 0);
    check("t5_r", oR, 0);
    run_op(1, 3, 4, 5, 6, 7, 42, "t5_after");

    // back-to-back with iVALID held high
    drive_ops(1, 3, 4, 5, 6);
    iVALID = 1'b1;
    tick();
    drive_ops(1, 1, 2, 3, 4);
    wait_valid(c0);
    check("t6_first_r", oR, 42);
    repeat (2) tick();
    iVALID = 1'b0;
    wait_valid(c1);
    check("t6_gap", c1 - c0, 8);
    check("t6_second_r", oR, 14);
    repeat (2) tick();

    // randomized traffic with occasional resets and consumer stalls
    for (int i = 0; i < 3000; i++) begin
      tick();
      iVALID = ($urandom_range(0, 2) != 0);
      iSEL   = $urandom_range(0, 1);
      iA0 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      iB0 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      iA1 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      iB1 = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      iREADY = ($urandom_range(0, 3) != 0);
      iRST   = ($urandom_range(0, 199) == 0);
    end
    tick();
    iRST = 1'b0; iVALID = 1'b0; iREADY = 1'b1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
